// File: rtl/cordic_pkg.sv
// cordic_pkg: shared definitions for the CORDIC NCO front end.
//   nco_state_t      controller state encoding (IDLE, RUN, SWEEP, DRAIN)
//   CORDIC_INV_GAIN  1/K in Q1.15, pre-scales Xin so the rotator output reaches full scale
//   PHASE_W          phase / frequency accumulator width
//   comp_amp()       clamps amplitude to [0, 32767] and applies 1/K
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DRAIN = 2'd3
    } nco_state_t;

    localparam logic [15:0] CORDIC_INV_GAIN = 16'h4DBA;
    localparam int          PHASE_W         = 32;

    // A negative amplitude clamps to 0. Once clamped the value is non-negative,
    // so the right shift truncates toward zero. The largest result is
    // 32767 * 0x4DBA >> 15 = 19897, so 16 bits always hold it.
    function automatic logic [15:0] comp_amp(input logic [15:0] amp);
        logic [31:0] prod;
        logic [15:0] amp_c;
        amp_c = amp[15] ? 16'd0 : amp;
        prod  = {16'd0, amp_c} * {16'd0, CORDIC_INV_GAIN};
        return prod[30:15];
    endfunction

endpackage

// File: rtl/cordic_valid_pipe.sv
// cordic_valid_pipe: DEPTH-stage shift register carrying {last, valid}
// alongside the rotator pipeline so they emerge with the rotator outputs.
//   clock, reset  rising-edge clock, async active-high reset (flushes every stage)
//   d             {last, valid} entering the rotator this cycle
//   q             {last, valid} delayed DEPTH cycles
module cordic_valid_pipe #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] d,
    output logic [1:0] q
);

    logic [1:0] sr [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= 2'b00;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/cordic_nco.sv
// cordic_nco: phase accumulator and sequencing front end for the pipelined
// CORDIC rotator. It produces angle/Xin/Yin every cycle. It tracks valid and
// last through a delay line matched to the rotator latency.
//   clock, reset                 rising-edge clock, async active-high reset
//   cfg_valid/cfg_ready          config handshake; ready only in IDLE
//   cfg_freq/phase/amp/step/count  phase increment, start phase, amplitude,
//                                sweep step, sweep length (0 = free-run)
//   start, stop                  begin generation (IDLE), end free-run (RUN)
//   busy                         high in RUN, SWEEP, DRAIN
//   angle, xin, yin              rotator inputs
//   in_valid, in_last            sample qualifiers at the rotator input
//   sample_valid, sample_last    the same qualifiers aligned to rotator outputs
//
// state | meaning
// IDLE  | config accepted, waiting for start
// RUN   | free-running at constant frequency until stop
// SWEEP | emitting cfg_count samples with linearly stepped frequency
// DRAIN | no new samples; waiting LATENCY cycles for the rotator to empty
module cordic_nco
    import cordic_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_freq,
    input  logic [31:0]        cfg_phase,
    input  logic [15:0]        cfg_amp,
    input  logic [31:0]        cfg_step,
    input  logic [15:0]        cfg_count,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic [31:0]        angle,
    output logic [WIDTH-1:0]   xin,
    output logic [WIDTH-1:0]   yin,
    output logic               in_valid,
    output logic               in_last,
    output logic               sample_valid,
    output logic               sample_last
);

    nco_state_t         state;
    logic [PHASE_W-1:0] freq_q, phase_q, step_q;
    logic [15:0]        amp_q, count_q;
    logic [PHASE_W-1:0] next_phase, freq_cur;
    logic [15:0]        remain;
    logic [15:0]        drain_cnt;
    logic [1:0]         pipe_q;

    logic               hs;
    logic [PHASE_W-1:0] freq_e, phase_e;
    logic [15:0]        amp_e, count_e;

    assign hs = cfg_valid && cfg_ready;

    // A config offered on the same edge as start takes effect immediately.
    always_comb begin
        freq_e  = hs ? cfg_freq  : freq_q;
        phase_e = hs ? cfg_phase : phase_q;
        amp_e   = hs ? cfg_amp   : amp_q;
        count_e = hs ? cfg_count : count_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            freq_q     <= '0;
            phase_q    <= '0;
            step_q     <= '0;
            amp_q      <= '0;
            count_q    <= '0;
            next_phase <= '0;
            freq_cur   <= '0;
            remain     <= '0;
            drain_cnt  <= '0;
            cfg_ready  <= 1'b1;
            busy       <= 1'b0;
            angle      <= '0;
            xin        <= '0;
            in_valid   <= 1'b0;
            in_last    <= 1'b0;
        end else begin
            if (hs) begin
                freq_q  <= cfg_freq;
                phase_q <= cfg_phase;
                step_q  <= cfg_step;
                amp_q   <= cfg_amp;
                count_q <= cfg_count;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= (count_e == 16'd0) ? ST_RUN : ST_SWEEP;
                        cfg_ready  <= 1'b0;
                        busy       <= 1'b1;
                        angle      <= phase_e;
                        next_phase <= phase_e + freq_e;
                        freq_cur   <= (count_e == 16'd0) ? freq_e
                                                         : freq_e + (hs ? cfg_step : step_q);
                        remain     <= count_e - 16'd1;
                        in_valid   <= 1'b1;
                        in_last    <= (count_e == 16'd1);
                        xin        <= WIDTH'(comp_amp(amp_e));
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state     <= ST_DRAIN;
                        in_valid  <= 1'b0;
                        drain_cnt <= 16'(LATENCY - 1);
                    end else begin
                        angle      <= next_phase;
                        next_phase <= next_phase + freq_cur;
                    end
                end
                ST_SWEEP: begin
                    // remain counts samples still owed after the one now on angle.
                    if (remain == 16'd0) begin
                        state     <= ST_DRAIN;
                        in_valid  <= 1'b0;
                        in_last   <= 1'b0;
                        drain_cnt <= 16'(LATENCY - 1);
                    end else begin
                        angle      <= next_phase;
                        next_phase <= next_phase + freq_cur;
                        freq_cur   <= freq_cur + step_q;
                        remain     <= remain - 16'd1;
                        in_last    <= (remain == 16'd1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 16'd0) begin
                        state     <= ST_IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign yin = '0;

    cordic_valid_pipe #(.DEPTH(LATENCY)) u_valid_pipe (
        .clock (clock),
        .reset (reset),
        .d     ({in_last, in_valid}),
        .q     (pipe_q)
    );

    assign sample_valid = pipe_q[0];
    assign sample_last  = pipe_q[1];

endmodule

// File: tb/tb_cordic_nco.sv
module tb_cordic_nco;

    localparam int WIDTH = 16;
    localparam int LAT   = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              cfg_valid, cfg_ready;
    logic [31:0]       cfg_freq, cfg_phase, cfg_step;
    logic [15:0]       cfg_amp, cfg_count;
    logic              start, stop, busy;
    logic [31:0]       angle;
    logic [WIDTH-1:0]  xin, yin;
    logic              in_valid, in_last, sample_valid, sample_last;

    int total = 0;
    int bad   = 0;

    localparam logic [103:0] RESET_VEC = {32'h0, 16'h0, 16'h0, 6'b000000, 1'b1};

    cordic_nco #(.WIDTH(WIDTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp),
        .cfg_step(cfg_step), .cfg_count(cfg_count),
        .start(start), .stop(stop), .busy(busy),
        .angle(angle), .xin(xin), .yin(yin),
        .in_valid(in_valid), .in_last(in_last),
        .sample_valid(sample_valid), .sample_last(sample_last)
    );

    always #5 clock = ~clock;

    function automatic logic [103:0] out_vec();
        return {angle, xin, yin, in_valid, in_last, sample_valid, sample_last, busy, cfg_ready};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cfg_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic set_cfg(input logic [31:0] f, input logic [31:0] p, input logic [15:0] a,
                           input logic [31:0] s, input logic [15:0] c);
        cfg_freq = f; cfg_phase = p; cfg_amp = a; cfg_step = s; cfg_count = c;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cfg_valid = 0; start = 0; stop = 0;
        set_cfg(0, 0, 0, 0, 0);
        step(); step();
        total++;
        if (out_vec() !== RESET_VEC) begin
            bad++; $display("FAIL reset_outputs got=%h want=%h", out_vec(), RESET_VEC);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_quadrants();
        int n;
        logic [31:0] ea;
        set_cfg(32'h4000_0000, 32'h0, 16'd32767, 32'h0, 16'd0);
        cfg_valid = 1; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        total++;
        if (xin !== 16'd19897 || yin !== 16'd0) begin
            bad++; $display("FAIL quad_xin_yin got=%0d/%0d want=19897/0", xin, yin);
        end
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            ea = 32'(k) << 30;
            if (k <= 4) begin
                total++;
                if (angle !== ea || in_valid !== 1'b1) begin
                    bad++; $display("FAIL quad_angle k=%0d got=%h/%b want=%h/1", k, angle, in_valid, ea);
                end
            end
            total++;
            if (sample_valid !== (k == 16)) begin
                bad++; $display("FAIL quad_sample_valid k=%0d got=%b want=%b", k, sample_valid, (k == 16));
            end
        end
        stop = 1; step(); stop = 0;
        total++;
        if (in_valid !== 1'b0 || angle !== 32'h0 || busy !== 1'b1) begin
            bad++; $display("FAIL quad_stop got in_valid=%b angle=%h busy=%b want 0/0/1", in_valid, angle, busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            step(); n++;
        end
        total++;
        if (n !== 16 || cfg_ready !== 1'b1) begin
            bad++; $display("FAIL quad_busy_fall got=%0d ready=%b want=16 ready=1", n, cfg_ready);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] ea [4];
        ea[0] = 32'h0; ea[1] = 32'h0; ea[2] = 32'h100; ea[3] = 32'h300;
        set_cfg(32'h0, 32'h0, 16'd1000, 32'h100, 16'd4);
        cfg_valid = 1; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) step();
            total++;
            if (angle !== ea[(k < 4) ? k : 3]) begin
                bad++; $display("FAIL sweep_angle k=%0d got=%h want=%h", k, angle, ea[(k < 4) ? k : 3]);
            end
            total++;
            if ({in_valid, in_last, sample_valid, sample_last, busy} !==
                {(k < 4), (k == 3), (k >= 16 && k <= 19), (k == 19), (k < 20)}) begin
                bad++;
                $display("FAIL sweep_flags k=%0d got=%b want=%b", k,
                         {in_valid, in_last, sample_valid, sample_last, busy},
                         {(k < 4), (k == 3), (k >= 16 && k <= 19), (k == 19), (k < 20)});
            end
        end
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL sweep_idle got=%b want=1", cfg_ready);
        end
    endtask

    task automatic test_wrap_and_handshake();
        bit ok;
        logic [31:0] ea [3];
        ea[0] = 32'hFFFF_FFF0; ea[1] = 32'h0000_0010; ea[2] = 32'h0000_0030;
        set_cfg(32'h20, 32'hFFFF_FFF0, 16'd100, 32'h0, 16'd0);
        cfg_valid = 1; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            total++;
            if (angle !== ea[k]) begin
                bad++; $display("FAIL wrap_angle k=%0d got=%h want=%h", k, angle, ea[k]);
            end
        end
        set_cfg(32'h1234, 32'h55, 16'd7, 32'h9, 16'd3);
        cfg_valid = 1;
        step();
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++; $display("FAIL hs_ready_run got=%b want=0", cfg_ready);
        end
        stop = 1; step(); stop = 0;
        step(); step();
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++; $display("FAIL hs_ready_drain got=%b want=0", cfg_ready);
        end
        cfg_valid = 0;
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL hs_drain_timeout got=busy want=idle");
        end
        start = 1; step(); start = 0;
        total++;
        if (angle !== 32'hFFFF_FFF0 || in_valid !== 1'b1) begin
            bad++; $display("FAIL hs_cfg_kept0 got=%h want=fffffff0", angle);
        end
        step();
        total++;
        if (angle !== 32'h0000_0010) begin
            bad++; $display("FAIL hs_cfg_kept1 got=%h want=00000010", angle);
        end
        stop = 1; step(); stop = 0;
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL hs_drain2_timeout got=busy want=idle");
        end
    endtask

    task automatic test_same_edge();
        bit ok;
        set_cfg(32'h1000, 32'h0, 16'd100, 32'h0, 16'd0);
        cfg_valid = 1; start = 1; step(); cfg_valid = 0; start = 0;
        total++;
        if (angle !== 32'h0 || in_valid !== 1'b1) begin
            bad++; $display("FAIL same_edge_s0 got=%h/%b want=0/1", angle, in_valid);
        end
        step();
        total++;
        if (angle !== 32'h1000) begin
            bad++; $display("FAIL same_edge_s1 got=%h want=00001000", angle);
        end
        step();
        total++;
        if (angle !== 32'h2000) begin
            bad++; $display("FAIL same_edge_s2 got=%h want=00002000", angle);
        end
        stop = 1; step(); stop = 0;
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL same_edge_timeout got=busy want=idle");
        end
    endtask

    task automatic test_amp_clamp();
        bit ok;
        logic [15:0] amps [2];
        logic [15:0] exps [2];
        amps[0] = 16'hFFFB; exps[0] = 16'd0;
        amps[1] = 16'd16384; exps[1] = 16'd9949;
        for (int i = 0; i < 2; i++) begin
            set_cfg(32'h10, 32'h0, amps[i], 32'h0, 16'd0);
            cfg_valid = 1; start = 1; step(); cfg_valid = 0; start = 0;
            total++;
            if (xin !== exps[i]) begin
                bad++; $display("FAIL amp_clamp i=%0d got=%0d want=%0d", i, xin, exps[i]);
            end
            stop = 1; step(); stop = 0;
            wait_idle(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL amp_timeout i=%0d got=busy want=idle", i);
            end
        end
    endtask

    task automatic test_reset_midstream();
        set_cfg(32'h10, 32'h100, 16'd32767, 32'h0, 16'd0);
        cfg_valid = 1; start = 1; step(); cfg_valid = 0; start = 0;
        for (int k = 0; k < 20; k++) step();
        total++;
        if (sample_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_pre_reset got=%b/%b want=1/1", sample_valid, busy);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (out_vec() !== RESET_VEC) begin
            bad++; $display("FAIL mid_reset_outputs got=%h want=%h", out_vec(), RESET_VEC);
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (sample_valid !== 1'b0 || in_valid !== 1'b0 || cfg_ready !== 1'b1) begin
                bad++; $display("FAIL mid_after_release k=%0d got=%b/%b/%b want=0/0/1",
                                k, sample_valid, in_valid, cfg_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_quadrants();
        test_sweep();
        test_wrap_and_handshake();
        test_same_edge();
        test_amp_clamp();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_nco.md
# cordic_nco

Phase-generation and control front end for the pipelined CORDIC rotator. It accumulates a programmable phase increment, with optional linear frequency sweep, and drives the rotator's `Xin`/`Yin`/`angle` inputs every cycle. `Xin` is gain-compensated so the rotator's outputs reach full scale. A valid/last delay line matched to the rotator latency tells downstream logic when `sine`/`cosine` carry a real sample.

## Interface
- `WIDTH`, 16: rotator data width; sets `Xin`/`Yin` width.
- `LATENCY`, 16: rotator latency in cycles (1 quadrant stage + `WIDTH-1` iterations = `WIDTH`).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cfg_valid`  in  1  config offered.
- `cfg_ready`  out  1  high only in IDLE; handshake when both high on an edge.
- `cfg_freq`  in  32  phase increment; full circle = 2^32.
- `cfg_phase`  in  32  start phase offset.
- `cfg_amp`  in  16  signed amplitude; negative treated as 0.
- `cfg_step`  in  32  per-sample increment added to frequency in sweep mode.
- `cfg_count`  in  16  sweep length in samples; 0 selects free-run.
- `start`  in  1  begin generation (IDLE only).
- `stop`  in  1  end free-run (RUN only).
- `busy`  out  1  high in RUN, SWEEP, DRAIN.
- `angle`  out  32  to rotator `angle`.
- `xin`  out  `WIDTH`  to rotator `Xin`.
- `yin`  out  `WIDTH`  to rotator `Yin`; always 0.
- `in_valid`  out  1  current `angle` is a real sample.
- `in_last`  out  1  final sample of a sweep.
- `sample_valid`  out  1  `in_valid` delayed `LATENCY` cycles; aligns with rotator outputs.
- `sample_last`  out  1  `in_last` delayed `LATENCY` cycles.

## Operation
- All outputs are registered. Reset value of every output is 0, except `cfg_ready`, which is 1 (IDLE).
- States and transitions:
  - IDLE → RUN on `start` when the latched count is 0.
  - IDLE → SWEEP on `start` when the latched count is nonzero.
  - RUN → DRAIN on `stop`.
  - SWEEP → DRAIN after the sample carrying `in_last`.
  - DRAIN → IDLE after `LATENCY` cycles with `in_valid` = 0.
- Config is latched on handshake. If `cfg_valid`, `cfg_ready` and `start` are all high on the same edge, the new config is used.
- `start` outside IDLE is ignored. `stop` outside RUN is ignored.
- Sample k:
  - `angle` = phase + Σ_{j<k} f_j, with f_0 = freq.
  - In RUN, f_{j+1} = f_j.
  - In SWEEP, f_{j+1} = f_j + step.
  - All phase and frequency arithmetic is modulo 2^32 (silent wrap).
- SWEEP emits exactly `cfg_count` samples. `in_last` is high on the final one.
- `xin` = (clamp(amp, 0, 32767) × 16'h4DBA) >>> 15, computed once at start.
  - 16'h4DBA ≈ 1/K = 0.60725.
  - Max `xin` = 19897.
  - 32-bit product, truncated toward zero.
- `angle` holds its last value when `in_valid` = 0.

## Timing
- `start` sampled at edge N → first sample (`angle` = phase, `in_valid` = 1) visible after edge N, then one sample per cycle.
- `in_valid` high in cycle t → `sample_valid` high in cycle t + `LATENCY`.
- `stop` sampled at edge M → no sample after edge M. `busy` falls `LATENCY` cycles after the last `in_valid` deasserts.
- Reset asserted mid-operation clears the state, accumulators and delay line immediately. No stale `sample_valid` is produced after release.

## Structure
- Shared package `cordic_pkg` holds:
  - state enum (IDLE, RUN, SWEEP, DRAIN);
  - `CORDIC_INV_GAIN = 16'h4DBA`;
  - phase-width constant 32.
- One sub-module, `cordic_valid_pipe`: a `LATENCY`-deep, 2-bit shift register carrying valid/last, with async reset.

## Test plan
- Reset:
  - Stimulus: assert `reset` mid-stream.
  - Required: all outputs 0, `cfg_ready` = 1; no `sample_valid` for 20 cycles after release.
- Free-run quadrants:
  - Stimulus: freq = 0x4000_0000, phase = 0, amp = 32767, `start`.
  - Required: `angle` = 0, 4000_0000, 8000_0000, C000_0000, 0 …; `xin` = 19897, `yin` = 0; `sample_valid` rises 16 cycles after `in_valid`.
- Sweep:
  - Stimulus: freq = 0, step = 0x100, count = 4.
  - Required: `angle` = 0, 0, 0x100, 0x300; `in_last` on the 4th sample; `sample_last` 16 cycles later; `busy` falls, IDLE reached.
- Wrap:
  - Stimulus: phase = 0xFFFF_FFF0, freq = 0x20.
  - Required: `angle` = FFFF_FFF0, 0000_0010, 0000_0030.
- Handshake edges:
  - Stimulus: `cfg_valid` during RUN/DRAIN.
  - Required: `cfg_ready` = 0 and config unchanged.
  - Stimulus: `cfg_valid` + `start` on the same edge in IDLE.
  - Required: new freq used for sample 1.
- Amplitude clamp:
  - Stimulus: amp = −5.
  - Required: `xin` = 0.
  - Stimulus: amp = 16384.
  - Required: `xin` = 9949.
